ycbcr_rgb_conv: RTL and testbench

Parametrised YCbCr-to-RGB colour-space converter for the camera video path. It sits between the CMOS capture / YCbCr processing stages and the RGB display or storage path. Relative to the fixed 8-bit BT.601 converter it adds:
- configurable sample width and coefficient precision;
- four conversion modes, latched per frame;
- a 4:2:2 input mode with on-the-fly chroma pairing;
- round-to-nearest arithmetic.

---
 rtl/ycbcr_rgb_conv.sv | 216 +++++++++++++++++++++
 tb/tb_ycbcr_rgb_conv.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_rgb_conv.sv
// YCbCr to RGB converter: per-frame mode latch, 4:2:2 chroma pairing and a
// four-stage fixed-point pipeline with round-to-nearest and output clamping.
module ycbcr_rgb_conv #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [DATA_W-1:0] per_img_Y,
  input  logic [DATA_W-1:0] per_img_Cb,
  input  logic [DATA_W-1:0] per_img_Cr,
  input  logic [1:0]        cfg_mode,
  input  logic              cfg_422,
  output logic              post_frame_vsync,
  output logic              post_frame_href,
  output logic              post_frame_clken,
  output logic [DATA_W-1:0] post_img_red,
  output logic [DATA_W-1:0] post_img_green,
  output logic [DATA_W-1:0] post_img_blue
);
  localparam int S   = DATA_W - 8;
  localparam int DW1 = DATA_W + 1;
  localparam int CW  = FRAC_W + 3;
  localparam int PW  = DATA_W + FRAC_W + 6;

  localparam logic [DATA_W-1:0]    YO_LIM = DATA_W'(32'd16 << S);
  localparam logic [DATA_W-1:0]    CM     = DATA_W'(32'd128 << S);
  localparam logic signed [PW-1:0] HALF   = PW'(1'b1) << (FRAC_W - 1);

  function automatic logic signed [CW-1:0] coef(input int milli);
    return CW'((milli * (32'sd1 <<< FRAC_W) + 32'sd500) / 32'sd1000);
  endfunction

  function automatic logic [DATA_W-1:0] clamp(input logic signed [PW-1:0] v);
    logic signed [PW-1:0] maxv;
    maxv = {{(PW-DATA_W){1'b0}}, {DATA_W{1'b1}}};
    if (v[PW-1]) return '0;
    else if (v > maxv) return '1;
    else return v[DATA_W-1:0];
  endfunction

  localparam logic signed [CW-1:0] K_Y_LIM  = coef(1164);
  localparam logic signed [CW-1:0] K_Y_FULL = coef(1000);
  localparam logic signed [CW-1:0] K6_RV = coef(1596), K6_GU = coef(391),
                                   K6_GV = coef(813),  K6_BU = coef(2018);
  localparam logic signed [CW-1:0] KJ_RV = coef(1402), KJ_GU = coef(344),
                                   KJ_GV = coef(714),  KJ_BU = coef(1772);
  localparam logic signed [CW-1:0] K7_RV = coef(1793), K7_GU = coef(213),
                                   K7_GV = coef(533),  K7_BU = coef(2112);

  typedef enum logic {EVEN = 1'b0, ODD = 1'b1} phase_e;

  logic              vsync_q, href_q, c422_q, c422_d;
  logic [1:0]        mode_q, mode_d;
  phase_e            phase_q, phase_d, ph_s;
  logic [DATA_W-1:0] cb_hold_q, cr_hold_q, cb_hold_d, cr_hold_d, cbh_s, crh_s;
  logic [DATA_W-1:0] cb_use_s, cr_use_s, yo_s;
  logic              vs_rise_s, href_rise_s, pix_s;
  logic signed [DW1-1:0] y_d, u_d, v_d;

  logic signed [DW1-1:0] s1_y_q, s1_u_q, s1_v_q, s2_y_q, s2_u_q, s2_v_q;
  logic [1:0]            s1_mode_q;
  logic signed [CW-1:0]  ky_s, krv_s, kgu_s, kgv_s, kbu_s;
  logic signed [PW-1:0]  s2_py_q, s2_prv_q, s2_pgu_q, s2_pgv_q, s2_pbu_q;
  logic                  s2_byp_q;
  logic signed [PW-1:0]  r_sum_s, g_sum_s, b_sum_s;
  logic signed [PW-1:0]  s3_r_d, s3_g_d, s3_b_d, s3_r_q, s3_g_q, s3_b_q;
  logic [3:0]            vs_pipe_q, hr_pipe_q, ck_pipe_q;

  // Front end: edge detection, chroma pairing, config latch and offset removal.
  always_comb begin
    vs_rise_s   = per_frame_vsync & ~vsync_q;
    href_rise_s = per_frame_href & ~href_q;
    pix_s       = per_frame_href & per_frame_clken;
    if (href_rise_s) begin
      ph_s  = EVEN;
      cbh_s = CM;
      crh_s = CM;
    end else begin
      ph_s  = phase_q;
      cbh_s = cb_hold_q;
      crh_s = cr_hold_q;
    end
    if (!c422_q) begin
      cb_use_s = per_img_Cb;
      cr_use_s = per_img_Cr;
    end else if (ph_s == EVEN) begin
      cb_use_s = per_img_Cb;
      cr_use_s = crh_s;
    end else begin
      cb_use_s = cbh_s;
      cr_use_s = per_img_Cb;
    end
    phase_d   = ph_s;
    cb_hold_d = cbh_s;
    cr_hold_d = crh_s;
    if (pix_s) begin
      if (ph_s == EVEN) begin
        phase_d   = ODD;
        cb_hold_d = per_img_Cb;
      end else begin
        phase_d   = EVEN;
        cr_hold_d = per_img_Cb;
      end
    end else begin
      phase_d = ph_s;
    end
    mode_d = vs_rise_s ? cfg_mode : mode_q;
    c422_d = vs_rise_s ? cfg_422 : c422_q;
    yo_s   = (mode_q == 2'd1) ? '0 : YO_LIM;
    // Bypass carries the raw components so that the later stages can pass them through.
    if (mode_q == 2'd3) begin
      y_d = $signed({1'b0, per_img_Y});
      u_d = $signed({1'b0, cb_use_s});
      v_d = $signed({1'b0, cr_use_s});
    end else begin
      y_d = $signed({1'b0, per_img_Y}) - $signed({1'b0, yo_s});
      u_d = $signed({1'b0, cb_use_s}) - $signed({1'b0, CM});
      v_d = $signed({1'b0, cr_use_s}) - $signed({1'b0, CM});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      mode_q    <= 2'd0;
      c422_q    <= 1'b0;
      phase_q   <= EVEN;
      cb_hold_q <= CM;
      cr_hold_q <= CM;
    end else begin
      vsync_q   <= per_frame_vsync;
      href_q    <= per_frame_href;
      mode_q    <= mode_d;
      c422_q    <= c422_d;
      phase_q   <= phase_d;
      cb_hold_q <= cb_hold_d;
      cr_hold_q <= cr_hold_d;
    end
  end

  // Coefficient set follows the mode that travelled with the pixel through S1.
  always_comb begin
    case (s1_mode_q)
      2'd0: begin
        ky_s = K_Y_LIM;  krv_s = K6_RV; kgu_s = K6_GU; kgv_s = K6_GV; kbu_s = K6_BU;
      end
      2'd1: begin
        ky_s = K_Y_FULL; krv_s = KJ_RV; kgu_s = KJ_GU; kgv_s = KJ_GV; kbu_s = KJ_BU;
      end
      2'd2: begin
        ky_s = K_Y_LIM;  krv_s = K7_RV; kgu_s = K7_GU; kgv_s = K7_GV; kbu_s = K7_BU;
      end
      default: begin
        ky_s = '0; krv_s = '0; kgu_s = '0; kgv_s = '0; kbu_s = '0;
      end
    endcase
  end

  always_comb begin
    r_sum_s = s2_py_q + s2_prv_q;
    g_sum_s = s2_py_q - s2_pgu_q - s2_pgv_q;
    b_sum_s = s2_py_q + s2_pbu_q;
    if (s2_byp_q) begin
      s3_r_d = PW'(s2_y_q);
      s3_g_d = PW'(s2_u_q);
      s3_b_d = PW'(s2_v_q);
    end else begin
      s3_r_d = (r_sum_s + HALF) >>> FRAC_W;
      s3_g_d = (g_sum_s + HALF) >>> FRAC_W;
      s3_b_d = (b_sum_s + HALF) >>> FRAC_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_y_q <= '0; s1_u_q <= '0; s1_v_q <= '0; s1_mode_q <= 2'd0;
      s2_py_q <= '0; s2_prv_q <= '0; s2_pgu_q <= '0; s2_pgv_q <= '0; s2_pbu_q <= '0;
      s2_y_q <= '0; s2_u_q <= '0; s2_v_q <= '0; s2_byp_q <= 1'b0;
      s3_r_q <= '0; s3_g_q <= '0; s3_b_q <= '0;
      post_img_red <= '0; post_img_green <= '0; post_img_blue <= '0;
      vs_pipe_q <= 4'd0; hr_pipe_q <= 4'd0; ck_pipe_q <= 4'd0;
    end else begin
      s1_y_q    <= y_d;
      s1_u_q    <= u_d;
      s1_v_q    <= v_d;
      s1_mode_q <= mode_q;
      s2_py_q   <= PW'(s1_y_q) * PW'(ky_s);
      s2_prv_q  <= PW'(s1_v_q) * PW'(krv_s);
      s2_pgu_q  <= PW'(s1_u_q) * PW'(kgu_s);
      s2_pgv_q  <= PW'(s1_v_q) * PW'(kgv_s);
      s2_pbu_q  <= PW'(s1_u_q) * PW'(kbu_s);
      s2_y_q    <= s1_y_q;
      s2_u_q    <= s1_u_q;
      s2_v_q    <= s1_v_q;
      s2_byp_q  <= (s1_mode_q == 2'd3);
      s3_r_q    <= s3_r_d;
      s3_g_q    <= s3_g_d;
      s3_b_q    <= s3_b_d;
      post_img_red   <= clamp(s3_r_q);
      post_img_green <= clamp(s3_g_q);
      post_img_blue  <= clamp(s3_b_q);
      vs_pipe_q <= {vs_pipe_q[2:0], per_frame_vsync};
      hr_pipe_q <= {hr_pipe_q[2:0], per_frame_href};
      ck_pipe_q <= {ck_pipe_q[2:0], per_frame_clken};
    end
  end

  assign post_frame_vsync = vs_pipe_q[3];
  assign post_frame_href  = hr_pipe_q[3];
  assign post_frame_clken = ck_pipe_q[3];
endmodule

// File: tb/tb_ycbcr_rgb_conv.sv
// Scoreboard bench for ycbcr_rgb_conv (DATA_W=8, FRAC_W=10) with directed,
// hand-computed vectors; a negedge monitor checks every valid output.
module tb_ycbcr_rgb_conv;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0, hr = 1'b0, ck = 1'b0;
  logic [7:0] y = 8'd0, cb = 8'd0, cr = 8'd0;
  logic [1:0] mode = 2'd0;
  logic       c422 = 1'b0;
  logic       pvs, phr, pck;
  logic [7:0] pr, pg, pb;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    int         t;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ycbcr_rgb_conv #(.DATA_W(8), .FRAC_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck),
    .per_img_Y(y), .per_img_Cb(cb), .per_img_Cr(cr),
    .cfg_mode(mode), .cfg_422(c422),
    .post_frame_vsync(pvs), .post_frame_href(phr), .post_frame_clken(pck),
    .post_img_red(pr), .post_img_green(pg), .post_img_blue(pb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic drive(input logic v, input logic h, input logic c);
    @(negedge clk);
    vs = v; hr = h; ck = c;
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) drive(1'b0, h, 1'b0);
  endtask

  task automatic frame(input logic [1:0] m, input logic c);
    mode = m;
    c422 = c;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic pix(input logic [7:0] iy, input logic [7:0] icb, input logic [7:0] icr,
                     input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                     input logic v = 1'b0);
    exp_t e;
    @(negedge clk);
    vs = v; hr = 1'b1; ck = 1'b1;
    y = iy; cb = icb; cr = icr;
    e.r = er; e.g = eg; e.b = eb; e.t = cyc;
    sb.push_back(e);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({pvs, phr, pck, pr, pg, pb} !== 27'd0) begin
      errors++;
      $display("FAIL %s: outputs vsync=%b href=%b clken=%b rgb=(%0d,%0d,%0d), required all 0",
               name, pvs, phr, pck, pr, pg, pb);
    end
  endtask

  // Monitor: every valid output pixel is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && pck && phr) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: rgb=(%0d,%0d,%0d) with empty scoreboard at cyc %0d",
                 pr, pg, pb, cyc);
      end else begin
        e = sb.pop_front();
        if ({pr, pg, pb} !== {e.r, e.g, e.b}) begin
          errors++;
          $display("FAIL rgb: got (%0d,%0d,%0d), required (%0d,%0d,%0d), issued cyc %0d",
                   pr, pg, pb, e.r, e.g, e.b, e.t);
        end
        checks++;
        if (cyc != e.t + 4) begin
          errors++;
          $display("FAIL latency: got %0d cycles, required 4", cyc - e.t);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;

    // Mode 0 corners and mid-grey
    frame(2'd0, 1'b0);
    pix(8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0);
    pix(8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
    pix(8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0);
    pix(8'd128, 8'd128, 8'd128, 8'd130, 8'd130, 8'd130);
    idle(2, 1'b0);

    // Mode 2
    frame(2'd2, 1'b0);
    pix(8'd100, 8'd150, 8'd90, 8'd30, 8'd113, 8'd144);
    idle(2, 1'b0);

    // Config latch: change ignored until the next vsync rise; that pixel keeps old mode
    frame(2'd0, 1'b0);
    pix(8'd128, 8'd128, 8'd128, 8'd130, 8'd130, 8'd130);
    mode = 2'd1;
    pix(8'd128, 8'd128, 8'd128, 8'd130, 8'd130, 8'd130);
    pix(8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0);
    pix(8'd128, 8'd128, 8'd128, 8'd130, 8'd130, 8'd130, 1'b1);
    pix(8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
    pix(8'd0,   8'd0,   8'd0,   8'd0,   8'd135, 8'd0);
    idle(2, 1'b0);

    // Mode 1 saturation
    pix(8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
    pix(8'd0,   8'd255, 8'd128, 8'd0,   8'd0,   8'd225);
    idle(2, 1'b0);

    // 4:2:2 pairing with a clken gap and an odd pixel count, then a fresh line
    frame(2'd1, 1'b1);
    pix(8'd128, 8'd200, 8'd7,  8'd128, 8'd103, 8'd255);
    idle(1, 1'b1);
    pix(8'd128, 8'd50,  8'd9,  8'd19,  8'd159, 8'd255);
    pix(8'd128, 8'd100, 8'd11, 8'd19,  8'd193, 8'd78);
    idle(2, 1'b0);
    pix(8'd128, 8'd128, 8'd13, 8'd128, 8'd128, 8'd128);
    idle(2, 1'b0);

    // Bypass
    frame(2'd3, 1'b0);
    pix(8'd17, 8'd99, 8'd200, 8'd17, 8'd99, 8'd200);
    idle(2, 1'b0);

    // Asynchronous reset mid-line while outputs are live
    frame(2'd0, 1'b0);
    pix(8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0);
    pix(8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
    pix(8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0);
    pix(8'd128, 8'd128, 8'd128, 8'd130, 8'd130, 8'd130);
    pix(8'd128, 8'd128, 8'd128, 8'd130, 8'd130, 8'd130);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    vs = 1'b0; hr = 1'b0; ck = 1'b0;
    #1;
    check_zero("async_reset");
    sb.delete();
    idle(2, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pix(8'd16,  8'd128, 8'd128, 8'd0,   8'd0,   8'd0);
    pix(8'd235, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
    pix(8'd0,   8'd0,   8'd0,   8'd0,   8'd136, 8'd0);
    pix(8'd128, 8'd128, 8'd128, 8'd130, 8'd130, 8'd130);
    idle(2, 1'b0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never appeared, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
